// File: rtl/avmm_mmio_arbiter_if.sv
// rtl/avmm_mmio_arbiter_if.sv - Avalon-MM command/response bundle
// Purpose: one Avalon-MM port (command + read response) with directional views.
// Ports:   master modport drives address/read/write/writedata/byteenable and
//          receives waitrequest/readdata/readdatavalid; slave modport is the mirror.
interface avmm_mmio_arbiter_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 18
);
   logic [ADDR_WIDTH-1:0]   address;
   logic                    read;
   logic                    write;
   logic [DATA_WIDTH-1:0]   writedata;
   logic [DATA_WIDTH/8-1:0] byteenable;
   logic                    waitrequest;
   logic [DATA_WIDTH-1:0]   readdata;
   logic                    readdatavalid;

   modport master (
      output address, read, write, writedata, byteenable,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/avmm_mmio_arbiter.sv
// rtl/avmm_mmio_arbiter.sv - two-master round-robin Avalon-MM arbiter with read-order tracking
// Purpose: shares one Avalon-MM slave between two masters; round-robin grant, grant
//          locked while the slave stalls, read responses routed back in order via a
//          master-ID FIFO, sticky flag on responses with nothing outstanding.
// Ports:   clk, reset_n (async, active-low)
//          m0, m1    : master-facing Avalon-MM ports (slave modport)
//          s         : slave-facing Avalon-MM port (master modport)
//          rsp_error : sticky, set by a read response with no read outstanding
module avmm_mmio_arbiter #(
   parameter int DATA_WIDTH  = 64,
   parameter int ADDR_WIDTH  = 18,
   parameter int MAX_PENDING = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   avmm_mmio_arbiter_if.slave   m0,
   avmm_mmio_arbiter_if.slave   m1,
   avmm_mmio_arbiter_if.master  s,
   output logic                 rsp_error
);

   localparam int PTR_W = $clog2(MAX_PENDING);
   localparam int CNT_W = PTR_W + 1;
   localparam int BE_W  = DATA_WIDTH / 8;

   typedef enum logic {
      ST_OPEN   = 1'b0,
      ST_LOCKED = 1'b1
   } lock_state_e;

   lock_state_e             state_q, state_d;
   logic                    lock_id_q, lock_id_d;
   logic                    prio_q, prio_d;
   logic [CNT_W-1:0]        pend_q, pend_d;
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [MAX_PENDING-1:0]  order_q, order_d;
   logic                    rsp_error_q, rsp_error_d;

   logic                    req0, req1, elig0, elig1, slot_free;
   logic                    gnt_vld, gnt_id, gnt_rd, accept;
   logic                    pend_nz, push, pop, rsp_id;
   logic [ADDR_WIDTH-1:0]   gnt_addr;
   logic [DATA_WIDTH-1:0]   gnt_wdata;
   logic [BE_W-1:0]         gnt_be;

   always_comb begin
      req0      = m0.read | m0.write;
      req1      = m1.read | m1.write;
      // A response in flight this cycle frees a slot in time for a new read.
      slot_free = (pend_q != CNT_W'(MAX_PENDING)) | s.readdatavalid;
      elig0     = req0 & (~m0.read | slot_free);
      elig1     = req1 & (~m1.read | slot_free);

      if (state_q == ST_LOCKED) begin
         gnt_id  = lock_id_q;
         gnt_vld = lock_id_q ? req1 : req0;
      end else begin
         gnt_id  = (elig0 & elig1) ? prio_q : elig1;
         gnt_vld = elig0 | elig1;
      end
      // Nothing reaches the slave while reset is asserted.
      gnt_vld   = gnt_vld & reset_n;

      // read+write together is treated as a read.
      gnt_rd    = gnt_id ? m1.read      : m0.read;
      gnt_addr  = gnt_id ? m1.address   : m0.address;
      gnt_wdata = gnt_id ? m1.writedata : m0.writedata;
      gnt_be    = gnt_id ? m1.byteenable : m0.byteenable;

      s.address    = gnt_addr;
      s.writedata  = gnt_wdata;
      s.byteenable = gnt_be;
      s.read       = gnt_vld & gnt_rd;
      s.write      = gnt_vld & ~gnt_rd;

      accept         = gnt_vld & ~s.waitrequest;
      m0.waitrequest = ~(accept & ~gnt_id);
      m1.waitrequest = ~(accept & gnt_id);

      pend_nz = (pend_q != '0);
      push    = accept & gnt_rd;
      pop     = s.readdatavalid & pend_nz & reset_n;
      rsp_id  = order_q[rd_ptr_q];

      m0.readdatavalid = pop & ~rsp_id;
      m1.readdatavalid = pop & rsp_id;
      m0.readdata      = s.readdata;
      m1.readdata      = s.readdata;

      state_d   = state_q;
      lock_id_d = lock_id_q;
      case (state_q)
         ST_OPEN: begin
            if (gnt_vld & s.waitrequest) begin
               state_d   = ST_LOCKED;
               lock_id_d = gnt_id;
            end
         end
         ST_LOCKED: begin
            // Leave on acceptance, or if the held master withdrew its command.
            if (!(gnt_vld & s.waitrequest)) state_d = ST_OPEN;
         end
         default: state_d = ST_OPEN;
      endcase

      prio_d   = accept ? ~gnt_id : prio_q;
      order_d  = order_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         order_d[wr_ptr_q] = gnt_id;
         wr_ptr_d          = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

      pend_d = pend_q;
      case ({push, pop})
         2'b10:   pend_d = pend_q + 1'b1;
         2'b01:   pend_d = pend_q - 1'b1;
         default: pend_d = pend_q;
      endcase

      rsp_error_d = rsp_error_q | (s.readdatavalid & ~pend_nz);
      rsp_error   = rsp_error_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_OPEN;
         lock_id_q   <= 1'b0;
         prio_q      <= 1'b0;
         pend_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         order_q     <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lock_id_q   <= lock_id_d;
         prio_q      <= prio_d;
         pend_q      <= pend_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         order_q     <= order_d;
         rsp_error_q <= rsp_error_d;
      end
   end

endmodule

// File: tb/tb_avmm_mmio_arbiter.sv
// tb/tb_avmm_mmio_arbiter.sv - bench for avmm_mmio_arbiter
module tb_avmm_mmio_arbiter;
   localparam int DW = 64;
   localparam int AW = 18;
   localparam int MP = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic rsp_error;

   always #5 clk = ~clk;

   avmm_mmio_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m0_if ();
   avmm_mmio_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m1_if ();
   avmm_mmio_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s_if ();

   avmm_mmio_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_PENDING(MP)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .m0        (m0_if),
      .m1        (m1_if),
      .s         (s_if),
      .rsp_error (rsp_error)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // master commands held until accepted, slave-side stimulus
   bit              cmd_v[2], cmd_rd[2], cmd_both[2];
   logic [AW-1:0]   cmd_addr[2];
   logic [DW-1:0]   cmd_wd[2];
   logic [DW/8-1:0] cmd_be[2];
   bit              s_wait, rsp_v;
   logic [DW-1:0]   rsp_data;

   // reference model: outstanding reads in slave order, round-robin pointer,
   // command stalled last cycle (must be re-presented), expected error flag
   int exp_q[$];
   int rr;
   bit hold_v;
   int hold_id;
   bit err_exp;
   int acc_id;

   task automatic apply();
      m0_if.read       = cmd_v[0] & cmd_rd[0];
      m0_if.write      = cmd_v[0] & (~cmd_rd[0] | cmd_both[0]);
      m0_if.address    = cmd_addr[0];
      m0_if.writedata  = cmd_wd[0];
      m0_if.byteenable = cmd_be[0];
      m1_if.read       = cmd_v[1] & cmd_rd[1];
      m1_if.write      = cmd_v[1] & (~cmd_rd[1] | cmd_both[1]);
      m1_if.address    = cmd_addr[1];
      m1_if.writedata  = cmd_wd[1];
      m1_if.byteenable = cmd_be[1];
      s_if.waitrequest   = s_wait;
      s_if.readdatavalid = rsp_v;
      s_if.readdata      = rsp_data;
   endtask

   task automatic model_cycle();
      bit el[2];
      bit gv, full, accept;
      int g;
      bit rdv[2];
      full = (exp_q.size() == MP) && !rsp_v;
      for (int x = 0; x < 2; x++) el[x] = cmd_v[x] && (!cmd_rd[x] || !full);
      g = 0;
      if (hold_v) begin
         g  = hold_id;
         gv = cmd_v[hold_id];
      end else begin
         gv = el[0] || el[1];
         if (el[0] && el[1]) g = rr;
         else if (el[1])     g = 1;
      end
      accept = gv && !s_wait;
      check("s_read",  s_if.read,  gv && cmd_rd[g]);
      check("s_write", s_if.write, gv && !cmd_rd[g]);
      if (gv) begin
         check("s_address", s_if.address, cmd_addr[g]);
         if (!cmd_rd[g]) begin
            check("s_writedata", s_if.writedata, cmd_wd[g]);
            check("s_byteenable", s_if.byteenable, cmd_be[g]);
         end
      end
      check("m0_waitrequest", m0_if.waitrequest, !(accept && g == 0));
      check("m1_waitrequest", m1_if.waitrequest, !(accept && g == 1));
      check("rsp_error", rsp_error, err_exp);
      rdv[0] = 1'b0;
      rdv[1] = 1'b0;
      if (rsp_v) begin
         if (exp_q.size() > 0) begin
            int id;
            id = exp_q.pop_front();
            rdv[id] = 1'b1;
            if (id == 0) check("m0_readdata", m0_if.readdata, rsp_data);
            else         check("m1_readdata", m1_if.readdata, rsp_data);
         end else begin
            err_exp = 1'b1;
         end
      end
      check("m0_readdatavalid", m0_if.readdatavalid, rdv[0]);
      check("m1_readdatavalid", m1_if.readdatavalid, rdv[1]);
      acc_id = -1;
      if (accept) begin
         acc_id = g;
         rr     = 1 - g;
         if (cmd_rd[g]) exp_q.push_back(g);
         cmd_v[g] = 1'b0;
      end
      hold_v  = gv && !accept;
      hold_id = g;
   endtask

   task automatic step();
      apply();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
      rsp_v = 1'b0;
   endtask

   task automatic issue(input int x, input bit rd, input logic [AW-1:0] a);
      cmd_v[x]    = 1'b1;
      cmd_rd[x]   = rd;
      cmd_both[x] = 1'b0;
      cmd_addr[x] = a;
      cmd_wd[x]   = {$urandom, $urandom};
      cmd_be[x]   = 8'($urandom);
   endtask

   task automatic drain();
      s_wait = 1'b0;
      for (int k = 0; k < 4 * MP && (exp_q.size() > 0 || cmd_v[0] || cmd_v[1]); k++) begin
         rsp_v    = (exp_q.size() > 0);
         rsp_data = {$urandom, $urandom};
         step();
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   task automatic rsp_route(input int x, input logic [DW-1:0] d);
      rsp_v    = 1'b1;
      rsp_data = d;
      apply();
      #1;
      check("route_vld_m0", m0_if.readdatavalid, x == 0);
      check("route_vld_m1", m1_if.readdatavalid, x == 1);
      if (x == 0) check("route_data_m0", m0_if.readdata, d);
      else        check("route_data_m1", m1_if.readdata, d);
      step();
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      cmd_v[0] = 1'b1; cmd_rd[0] = 1'b1;
      cmd_v[1] = 1'b1; cmd_rd[1] = 1'b0;
      rsp_v    = 1'b1;
      s_wait   = 1'b0;
      apply();
      #1;
      check("rst_s_read",   s_if.read, 1'b0);
      check("rst_s_write",  s_if.write, 1'b0);
      check("rst_m0_wait",  m0_if.waitrequest, 1'b1);
      check("rst_m1_wait",  m1_if.waitrequest, 1'b1);
      check("rst_m0_rdv",   m0_if.readdatavalid, 1'b0);
      check("rst_m1_rdv",   m1_if.readdatavalid, 1'b0);
      check("rst_rsp_error", rsp_error, 1'b0);
      @(posedge clk);
      #1;
      cmd_v[0] = 1'b0;
      cmd_v[1] = 1'b0;
      rsp_v    = 1'b0;
      apply();
      reset_n  = 1'b1;
      exp_q.delete();
      rr      = 0;
      hold_v  = 1'b0;
      err_exp = 1'b0;
   endtask

   initial begin
      for (int x = 0; x < 2; x++) begin
         cmd_v[x] = 0; cmd_rd[x] = 0; cmd_both[x] = 0;
         cmd_addr[x] = '0; cmd_wd[x] = '0; cmd_be[x] = '0;
      end
      s_wait = 0; rsp_v = 0; rsp_data = '0;
      apply();
      #2;
      do_reset();

      // idle after reset
      step();

      // tie: m0 then m1, repeated tie back to m0
      issue(0, 1'b1, 18'h10);
      issue(1, 1'b1, 18'h20);
      step(); check("tie_c1", acc_id, 0);
      step(); check("tie_c2", acc_id, 1);
      issue(0, 1'b1, 18'h30);
      issue(1, 1'b1, 18'h38);
      step(); check("tie_repeat", acc_id, 0);
      step(); check("tie_repeat_m1", acc_id, 1);
      drain();

      // lock: m1 write stalled 3 cycles while m0 requests
      s_wait = 1'b1;
      issue(1, 1'b0, 18'h40);
      step(); check("lock_c1_acc", acc_id, -1);
      issue(0, 1'b1, 18'h100);
      for (int i = 0; i < 2; i++) begin
         apply();
         #1;
         check("lock_addr", s_if.address, 18'h40);
         step();
         check("lock_acc", acc_id, -1);
      end
      s_wait = 1'b0;
      step(); check("lock_c4", acc_id, 1);
      step(); check("lock_then_m0", acc_id, 0);
      drain();

      // routing of three responses
      issue(0, 1'b1, 18'h8);  step();
      issue(1, 1'b1, 18'h10); step();
      issue(0, 1'b1, 18'h18); step();
      rsp_route(0, 64'hA);
      rsp_route(1, 64'hB);
      rsp_route(0, 64'hC);

      // spurious response, then normal traffic still routes
      rsp_v = 1'b1;
      rsp_data = 64'hDEAD;
      apply();
      #1;
      check("spur_m0_rdv", m0_if.readdatavalid, 1'b0);
      check("spur_m1_rdv", m1_if.readdatavalid, 1'b0);
      step();
      check("spur_err", rsp_error, 1'b1);
      issue(1, 1'b1, 18'h44); step();
      rsp_route(1, 64'h55);

      // full: 16 outstanding, write passes, read enters with first response
      for (int i = 0; i < MP; i++) begin
         issue(0, 1'b1, AW'(i * 8));
         step();
      end
      issue(0, 1'b1, 18'h200);
      issue(1, 1'b0, 18'h300);
      step(); check("full_write_acc", acc_id, 1);
      step(); check("full_read_held", acc_id, -1);
      rsp_v = 1'b1;
      rsp_data = {$urandom, $urandom};
      step(); check("full_read_on_rsp", acc_id, 0);
      drain();

      // reset with 5 reads in flight
      for (int i = 0; i < 5; i++) begin
         issue(i % 2, 1'b1, AW'(i * 16));
         step();
      end
      do_reset();
      check("post_rst_err", rsp_error, 1'b0);
      rsp_v = 1'b1;
      rsp_data = 64'h77;
      step();
      step();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         for (int x = 0; x < 2; x++) begin
            if (!cmd_v[x] && $urandom_range(0, 99) < 50) begin
               issue(x, $urandom_range(0, 1) == 1, AW'($urandom));
               if (cmd_rd[x] && $urandom_range(0, 9) == 0) cmd_both[x] = 1'b1;
            end
         end
         s_wait   = ($urandom_range(0, 99) < 30);
         rsp_data = {$urandom, $urandom};
         if (exp_q.size() > 0) rsp_v = ($urandom_range(0, 99) < (((i / 400) % 2 == 1) ? 45 : 8));
         else                  rsp_v = ($urandom_range(0, 199) == 0);
         step();
         if ($urandom_range(0, 999) == 0) do_reset();
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
